// File: rtl/vga_reg_pkg.sv
// Shared definitions for the register-overlay arbiter: RGB stream fields,
// 3-bit colours and the arbiter state type.
package vga_reg_pkg;

  localparam int unsigned STR_W     = 26;
  localparam int unsigned ACTIVE_BIT = 0;
  localparam int unsigned VS_BIT     = 1;
  localparam int unsigned HS_BIT     = 2;
  localparam int unsigned YC_LO      = 3;
  localparam int unsigned YC_HI      = 12;
  localparam int unsigned XC_LO      = 13;
  localparam int unsigned XC_HI      = 22;
  localparam int unsigned RGB_LO     = 23;
  localparam int unsigned RGB_HI     = 25;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned XY_W   = 20;
  localparam int unsigned POS_W  = 10;
  localparam int unsigned ZOOM_W = 3;
  localparam int unsigned ID_W   = 3;
  localparam int unsigned CNT_W  = 8;

  localparam logic [2:0] COL_BLACK   = 3'b000;
  localparam logic [2:0] COL_BLUE    = 3'b001;
  localparam logic [2:0] COL_GREEN   = 3'b010;
  localparam logic [2:0] COL_CYAN    = 3'b011;
  localparam logic [2:0] COL_RED     = 3'b100;
  localparam logic [2:0] COL_MAGENTA = 3'b101;
  localparam logic [2:0] COL_YELLOW  = 3'b110;
  localparam logic [2:0] COL_WHITE   = 3'b111;

  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } arbState_t;

endpackage

// File: rtl/vga_reg_arb_if.sv
// Requester/renderer bundle of the register-overlay arbiter.
interface vga_reg_arb_if
  import vga_reg_pkg::*;
#(
  parameter int unsigned N_SRC = 4
) ();

  logic [N_SRC-1:0]        req;
  logic [DATA_W*N_SRC-1:0] data;
  logic [XY_W*N_SRC-1:0]   xy;
  logic [ZOOM_W-1:0]       zoom_i;
  logic [N_SRC-1:0]        ack;
  logic [DATA_W-1:0]       register;
  logic [POS_W-1:0]        x_pos;
  logic [POS_W-1:0]        y_pos;
  logic [ZOOM_W-1:0]       zoom;
  logic                    valid;
  logic [ID_W-1:0]         grant_id;

  modport master (
    output req, data, xy, zoom_i,
    input  ack, register, x_pos, y_pos, zoom, valid, grant_id
  );

  modport slave (
    input  req, data, xy, zoom_i,
    output ack, register, x_pos, y_pos, zoom, valid, grant_id
  );

endinterface

// File: rtl/vga_rr_pick.sv
// Rotating-priority picker: first set request at or after startIdx wins.
// With startIdx tied to 0 it is a plain lowest-index priority encoder.
module vga_rr_pick
  import vga_reg_pkg::*;
#(
  parameter int unsigned N_SRC = 4
) (
  input  logic [N_SRC-1:0] reqVec,
  input  logic [ID_W-1:0]  startIdx,
  output logic [N_SRC-1:0] gnt,
  output logic [ID_W-1:0]  gntIdx,
  output logic             gntAny
);

  localparam int unsigned IW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  int unsigned cand;

  always_comb begin
    gnt    = '0;
    gntIdx = '0;
    gntAny = 1'b0;
    cand   = 0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      cand = 32'(startIdx) + i;
      if (cand >= N_SRC) cand = cand - N_SRC;
      if (!gntAny && reqVec[IW'(cand)]) begin
        gntAny           = 1'b1;
        gnt[IW'(cand)]   = 1'b1;
        gntIdx           = ID_W'(cand);
      end
    end
  end

endmodule

// File: rtl/vga_reg_arb.sv
// Frame-synchronous arbiter choosing which requester's register value the
// overlay renderer shows. Define VGA_REG_ARB_FIXED_PRIO_EN for fixed priority.
module vga_reg_arb
  import vga_reg_pkg::*;
#(
  parameter int unsigned N_SRC       = 4,
  parameter int unsigned HOLD_FRAMES = 2
) (
  input  logic             px_clk,
  input  logic             reset,
  input  logic [STR_W-1:0] strRGB_i,
  vga_reg_arb_if.slave     bus
);

  arbState_t          state;
  logic [CNT_W-1:0]   cnt;
  logic               vsQ;
  logic               frameTick;
  logic               grantNow;
  logic [ID_W-1:0]    startIdx;
  logic [N_SRC-1:0]   pickGnt;
  logic [ID_W-1:0]    pickIdx;
  logic               pickAny;
  logic [DATA_W-1:0]  selData;
  logic [XY_W-1:0]    selXy;
  logic               unusedStr;

  // Only VS matters here; the rest of the stream is just observed.
  assign unusedStr = ^{strRGB_i[STR_W-1:HS_BIT], strRGB_i[ACTIVE_BIT]};

  assign frameTick = strRGB_i[VS_BIT] & ~vsQ;
  assign grantNow  = frameTick & pickAny & ((state == IDLE) || (cnt == '0));

  vga_rr_pick #(.N_SRC(N_SRC)) uPick (
    .reqVec   (bus.req),
    .startIdx (startIdx),
    .gnt      (pickGnt),
    .gntIdx   (pickIdx),
    .gntAny   (pickAny)
  );

`ifdef VGA_REG_ARB_FIXED_PRIO_EN
  assign startIdx = '0;
`else
  logic [ID_W-1:0] rrPtr;

  // Search restarts just past the last winner; moves only on a grant.
  always_ff @(posedge px_clk) begin
    if (reset) begin
      rrPtr <= '0;
    end else if (grantNow) begin
      rrPtr <= (pickIdx == ID_W'(N_SRC - 1)) ? '0 : pickIdx + ID_W'(1);
    end
  end

  assign startIdx = rrPtr;
`endif

  always_comb begin
    selData = '0;
    selXy   = '0;
    for (int unsigned k = 0; k < N_SRC; k++) begin
      if (pickGnt[k]) begin
        selData = bus.data[DATA_W*k +: DATA_W];
        selXy   = bus.xy[XY_W*k +: XY_W];
      end
    end
  end

  // Outputs only move on a frame tick so a displayed value never tears.
  always_ff @(posedge px_clk) begin
    if (reset) begin
      vsQ          <= 1'b0;
      state        <= IDLE;
      cnt          <= '0;
      bus.ack      <= '0;
      bus.register <= '0;
      bus.x_pos    <= '0;
      bus.y_pos    <= '0;
      bus.zoom     <= '0;
      bus.valid    <= 1'b0;
      bus.grant_id <= '0;
    end else begin
      vsQ     <= strRGB_i[VS_BIT];
      bus.ack <= '0;
      if (grantNow) begin
        bus.ack      <= pickGnt;
        bus.register <= selData;
        bus.x_pos    <= selXy[POS_W-1:0];
        bus.y_pos    <= selXy[XY_W-1:POS_W];
        bus.zoom     <= bus.zoom_i;
        bus.grant_id <= pickIdx;
        bus.valid    <= 1'b1;
        cnt          <= CNT_W'(HOLD_FRAMES - 1);
        state        <= SHOW;
      end else if (frameTick && (state == SHOW)) begin
        if (cnt != '0) begin
          cnt <= cnt - CNT_W'(1);
        end else begin
          bus.valid <= 1'b0;
          state     <= IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_reg_arb.sv
// Frame-level bench for vga_reg_arb: per-frame vector table with a
// scoreboard of expected overlay outputs, plus reset corner sequences.
module tb_vga_reg_arb;
  import vga_reg_pkg::*;

  localparam int unsigned NS = 4;

  typedef struct packed {
    logic [3:0] req;
    logic [3:0] midReq;
    logic       setData0;
    logic [3:0] expAck;
    logic       expValid;
  } vec_t;

  typedef struct packed {
    logic [3:0]  ack;
    logic        valid;
    logic [2:0]  gid;
    logic [15:0] regv;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [2:0]  zoom;
  } exp_t;

  logic             clk;
  logic             reset;
  logic [STR_W-1:0] strRGB;

  vga_reg_arb_if #(.N_SRC(NS)) bus ();

  vga_reg_arb #(.N_SRC(NS), .HOLD_FRAMES(2)) dut (
    .px_clk   (clk),
    .reset    (reset),
    .strRGB_i (strRGB),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned passCnt = 0;
  int unsigned totalCnt = 0;

  vec_t        vecs[$];
  exp_t        sbQ[$];
  exp_t        cur;
  logic [15:0] dataArr[NS];
  logic [2:0]  zoomDrv;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    totalCnt++;
    if (act !== expv) $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    else passCnt++;
  endtask

  task automatic driveSrc();
    for (int k = 0; k < NS; k++) begin
      bus.data[16*k +: 16] = dataArr[k];
      bus.xy[20*k +: 20]   = {10'(100 + k), 10'(10 + k)};
    end
  endtask

  function automatic int ackIdx(input logic [3:0] a);
    ackIdx = -1;
    for (int k = NS - 1; k >= 0; k--) if (a[k]) ackIdx = k;
  endfunction

  task automatic checkOut(input string tag, input exp_t e, input logic [3:0] expAck);
    chk({tag, ".ack"},      32'(bus.ack),      32'(expAck));
    chk({tag, ".valid"},    32'(bus.valid),    32'(e.valid));
    chk({tag, ".grant_id"}, 32'(bus.grant_id), 32'(e.gid));
    chk({tag, ".register"}, 32'(bus.register), 32'(e.regv));
    chk({tag, ".xy"},       {12'd0, bus.y_pos, bus.x_pos}, {12'd0, e.y, e.x});
    chk({tag, ".zoom"},     32'(bus.zoom),     32'(e.zoom));
  endtask

  // One frame: glitchy mid-frame req, real req before VS rise, check at tick.
  task automatic runFrame(input int idx, input vec_t v);
    exp_t e;
    int   w;
    @(negedge clk);
    bus.req = v.midReq;
    repeat (2) @(negedge clk);
    if (v.setData0) begin
      dataArr[0] = 16'hBEEF;
      driveSrc();
    end
    zoomDrv    = zoomDrv + 3'd3;
    bus.zoom_i = zoomDrv;
    bus.req    = v.req;
    e       = cur;
    e.ack   = v.expAck;
    e.valid = v.expValid;
    w = ackIdx(v.expAck);
    if (w >= 0) begin
      e.gid  = 3'(w);
      e.regv = dataArr[w];
      e.x    = 10'(10 + w);
      e.y    = 10'(100 + w);
      e.zoom = zoomDrv;
    end
    sbQ.push_back(e);
    @(negedge clk);
    strRGB[VS_BIT] = 1'b1;
    @(posedge clk);
    #1;
    if (sbQ.size() == 0) begin
      chk($sformatf("f%0d.sbq", idx), 32'd0, 32'd1);
    end else begin
      cur = sbQ.pop_front();
      checkOut($sformatf("f%0d.tick", idx), cur, cur.ack);
    end
    @(negedge clk);
    strRGB[VS_BIT] = 1'b0;
    bus.req = 4'b0000;
    repeat (3) @(negedge clk);
    checkOut($sformatf("f%0d.stable", idx), cur, 4'b0000);
  endtask

  function automatic vec_t mk(input logic [3:0] r, input logic [3:0] m, input logic d,
                              input logic [3:0] a, input logic vld);
    vec_t v;
    v.req = r; v.midReq = m; v.setData0 = d; v.expAck = a; v.expValid = vld;
    return v;
  endfunction

  initial begin
    exp_t zeroE;
    zeroE = '0;
`ifdef VGA_REG_ARB_FIXED_PRIO_EN
    vecs.push_back(mk(4'b0110, 4'b0000, 1'b0, 4'b0010, 1'b1));
    vecs.push_back(mk(4'b0110, 4'b0000, 1'b0, 4'b0000, 1'b1));
    vecs.push_back(mk(4'b0110, 4'b0001, 1'b0, 4'b0010, 1'b1));
    vecs.push_back(mk(4'b0110, 4'b0000, 1'b0, 4'b0000, 1'b1));
    vecs.push_back(mk(4'b0110, 4'b0000, 1'b0, 4'b0010, 1'b1));
    vecs.push_back(mk(4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b1));
    vecs.push_back(mk(4'b1100, 4'b0000, 1'b0, 4'b0100, 1'b1));
    vecs.push_back(mk(4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b1));
    vecs.push_back(mk(4'b0000, 4'b1111, 1'b0, 4'b0000, 1'b0));
    vecs.push_back(mk(4'b0001, 4'b0110, 1'b0, 4'b0001, 1'b1));
`else
    vecs.push_back(mk(4'b1111, 4'b0000, 1'b0, 4'b0001, 1'b1));
    vecs.push_back(mk(4'b1111, 4'b0000, 1'b0, 4'b0000, 1'b1));
    vecs.push_back(mk(4'b1111, 4'b0101, 1'b0, 4'b0010, 1'b1));
    vecs.push_back(mk(4'b1111, 4'b0000, 1'b0, 4'b0000, 1'b1));
    vecs.push_back(mk(4'b1111, 4'b0000, 1'b0, 4'b0100, 1'b1));
    vecs.push_back(mk(4'b1111, 4'b0000, 1'b0, 4'b0000, 1'b1));
    vecs.push_back(mk(4'b1111, 4'b0000, 1'b0, 4'b1000, 1'b1));
    vecs.push_back(mk(4'b1111, 4'b0000, 1'b0, 4'b0000, 1'b1));
    vecs.push_back(mk(4'b1111, 4'b0000, 1'b0, 4'b0001, 1'b1));
    vecs.push_back(mk(4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b1));
    vecs.push_back(mk(4'b0001, 4'b0000, 1'b0, 4'b0001, 1'b1));
    vecs.push_back(mk(4'b0100, 4'b0000, 1'b0, 4'b0000, 1'b1));
    vecs.push_back(mk(4'b0100, 4'b0000, 1'b0, 4'b0100, 1'b1));
    vecs.push_back(mk(4'b0100, 4'b0000, 1'b0, 4'b0000, 1'b1));
    vecs.push_back(mk(4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0));
    vecs.push_back(mk(4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0));
    vecs.push_back(mk(4'b0010, 4'b1111, 1'b0, 4'b0010, 1'b1));
    vecs.push_back(mk(4'b0000, 4'b1000, 1'b0, 4'b0000, 1'b1));
    vecs.push_back(mk(4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0));
    vecs.push_back(mk(4'b1001, 4'b0000, 1'b0, 4'b1000, 1'b1));
    vecs.push_back(mk(4'b1001, 4'b0000, 1'b0, 4'b0000, 1'b1));
    vecs.push_back(mk(4'b1001, 4'b0000, 1'b0, 4'b0001, 1'b1));
    vecs.push_back(mk(4'b1001, 4'b0000, 1'b0, 4'b0000, 1'b1));
    vecs.push_back(mk(4'b1000, 4'b0000, 1'b0, 4'b1000, 1'b1));
`endif

    for (int k = 0; k < NS; k++) dataArr[k] = 16'hA000 + 16'(k * 16'h0111);
    zoomDrv    = 3'd0;
    reset      = 1'b1;
    strRGB     = 26'h2A5_5A5A & ~(26'd1 << VS_BIT);
    bus.req    = '0;
    bus.zoom_i = '0;
    driveSrc();
    repeat (3) @(posedge clk);
    #1;
    checkOut("reset", zeroE, 4'b0000);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checkOut("postreset", zeroE, 4'b0000);
    cur = zeroE;

    for (int i = 0; i < vecs.size(); i++) runFrame(i, vecs[i]);

    // Reset coincident with a frame tick while a grant is on display.
    @(negedge clk);
    bus.req        = 4'b1111;
    strRGB[VS_BIT] = 1'b1;
    reset          = 1'b1;
    @(posedge clk);
    #1;
    checkOut("rst_on_tick", zeroE, 4'b0000);
    @(negedge clk);
    strRGB[VS_BIT] = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checkOut("rst_idle", zeroE, 4'b0000);

    // Back in IDLE with pointer reset: the next tick grants source 0.
    cur = zeroE;
    runFrame(100, mk(4'b1111, 4'b0000, 1'b0, 4'b0001, 1'b1));

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
